// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that processes DIGIT bits of two WIDTH-bit
// operands per clock through one DIGIT-bit adder chain and a registered carry.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input that selects A - B.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; results held
// ST_RUN  | one digit per clock, LSB digit first
// ST_DONE | single-cycle done pulse; a start here is accepted immediately
`timescale 1ns/1ps

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_v;

    logic [WIDTH-1:0] w_b_cap;
    logic             w_c_cap;
    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0] w_sum_dig;
    logic             w_cout_dig;
    logic             w_cmsb_dig;
    logic [WIDTH-1:0] w_s_next;

    // Subtraction is folded into the captured operand: A + ~B + 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_cap = sub ? ~B : B;
    assign w_c_cap = sub ? 1'b1 : Cin;
`else
    assign w_b_cap = B;
    assign w_c_cap = Cin;
`endif

    assign w_last  = (r_cnt == CW'(N - 1));
    assign w_a_dig = r_a[DIGIT-1:0];
    assign w_b_dig = r_b[DIGIT-1:0];

    assign {w_cout_dig, w_sum_dig} = {1'b0, w_a_dig} + {1'b0, w_b_dig}
                                   + {{DIGIT{1'b0}}, r_carry};

    // Carry into the digit's top bit recovered from that bit's sum: s ^ a ^ b.
    assign w_cmsb_dig = w_sum_dig[DIGIT-1] ^ w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1];

    // New digit enters at the top; after N digits the LSB digit sits at bit 0.
    assign w_s_next = (r_s_sh >> DIGIT) | (WIDTH'(w_sum_dig) << (WIDTH - DIGIT));

    assign S    = r_sum;
    assign Cout = r_cout;
    assign V    = r_v;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode, handshake outputs and start acceptance.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, digit-serial datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_v     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= w_b_cap;
            r_carry <= w_c_cap;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_s_sh  <= w_s_next;
            r_carry <= w_cout_dig;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_s_next;
                r_cout <= w_cout_dig;
                r_v    <= w_cmsb_dig ^ w_cout_dig;
            end
        end
    end

endmodule
